// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
//
// Package div_pkg:
//   div_state_t  - controller states IDLE, ITER, FIX, DONE
//   DIV_WIDTH    - default divisor/quotient/remainder width
//   DBZ_QUOTIENT - quotient reported on divide-by-zero or overflow (all ones)
//   cnt_width()  - iteration counter width for a given operand width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 8;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    // Counter runs WIDTH-1 down to 0, so clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - go/done handshake and operand/result bundle of the divider
//
// Signals:
//   go, dividend[2W], divisor[W]                  - request side (master drives)
//   busy, done, quotient, remainder, result, dbz, ovf - response side (slave drives)
// Modports: master (requester), slave (divider).
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic                 go;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic [2*WIDTH-1:0]   result;
    logic                 dbz;
    logic                 ovf;

    modport master (
        output go, dividend, divisor,
        input  busy, done, quotient, remainder, result, dbz, ovf
    );

    modport slave (
        input  go, dividend, divisor,
        output busy, done, quotient, remainder, result, dbz, ovf
    );

endinterface

// File: rtl/seq_divider_addsub.sv
// rtl/seq_divider_addsub.sv - ripple-carry N-bit add/subtract for the divider datapath
//
// Ports:
//   a, b - operands (N bits, two's complement)
//   sub  - 1: y = a - b, 0: y = a + b
//   y    - N-bit result, carry out discarded
module div_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    // Subtraction is a + ~b + 1: invert b and inject sub as the carry in.
    logic [N-1:0] bx;
    logic [N-1:0] c;

    assign bx   = b ^ {N{sub}};
    assign c[0] = sub;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign y[i] = a[i] ^ bx[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a[i] & bx[i]) | (a[i] & c[i]) | (bx[i] & c[i]);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential non-restoring divider, 2W-bit / W-bit, one quotient bit per clock
//
// Ports:
//   clk - clock, all state updates on posedge
//   rst - synchronous active-low reset
//   bus - seq_divider_if.slave: go/dividend/divisor in;
//         busy/done/quotient/remainder/result/dbz/ovf out
// Optional: define SEQ_DIVIDER_SIGNED_EN for two's complement operands
// (magnitude division with sign fix-up; quotient magnitude >= 2^(W-1) flags ovf).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] QUOTIENT_SAT = {WIDTH{DBZ_QUOTIENT[0]}};

    div_state_t         state;
    div_state_t         state_next;

    logic [WIDTH:0]     p;          // signed partial remainder
    logic [WIDTH-1:0]   q;          // dividend low half, becomes the quotient
    logic [WIDTH-1:0]   d;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;
    logic               dbz_r;
    logic               ovf_r;

    logic [2*WIDTH-1:0] mag_dvd;
    logic [WIDTH-1:0]   mag_dvs;
    logic               too_big;
    logic               div_zero;

    logic [WIDTH:0]     p_shift;
    logic [WIDTH:0]     as_a;
    logic [WIDTH:0]     as_y;
    logic               as_sub;
    logic [WIDTH-1:0]   rem_mag;

    // ---------------------------------------------------------------
    // Operand front end
    // ---------------------------------------------------------------
    assign div_zero = (bus.divisor == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    always_comb begin
        mag_dvd = bus.dividend;
        mag_dvs = bus.divisor;
        if (bus.dividend[2*WIDTH-1]) mag_dvd = -bus.dividend;
        if (bus.divisor[WIDTH-1])    mag_dvs = -bus.divisor;
        // Quotient magnitude >= 2^(W-1) cannot be represented with a sign bit;
        // the most-negative result is flagged too, by design.
        too_big = (mag_dvd[2*WIDTH-1:WIDTH-1] >= {1'b0, mag_dvs});
    end
`else
    assign mag_dvd = bus.dividend;
    assign mag_dvs = bus.divisor;
    assign too_big = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
`endif

    // ---------------------------------------------------------------
    // Shared adder: ITER adds/subtracts on the shifted P, FIX restores P.
    // Wrap-around of the shifted value is harmless: the true result of
    // each step always lies in [-D, D) and so fits in W+1 bits.
    // ---------------------------------------------------------------
    assign p_shift = {p[WIDTH-1:0], q[WIDTH-1]};

    always_comb begin
        as_a   = p;
        as_sub = 1'b0;
        if (state == ITER) begin
            as_a   = p_shift;
            as_sub = ~p[WIDTH];
        end
    end

    div_addsub #(.N(WIDTH + 1)) u_addsub (
        .a   (as_a),
        .b   ({1'b0, d}),
        .sub (as_sub),
        .y   (as_y)
    );

    assign rem_mag = p[WIDTH] ? as_y[WIDTH-1:0] : p[WIDTH-1:0];

    // ---------------------------------------------------------------
    // Controller
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.go) state_next = (div_zero || too_big) ? DONE : ITER;
            ITER: if (count == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            p           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        p     <= {1'b0, mag_dvd[2*WIDTH-1:WIDTH]};
                        q     <= mag_dvd[WIDTH-1:0];
                        d     <= mag_dvs;
                        count <= CW'(WIDTH - 1);
                        dbz_r <= 1'b0;
                        ovf_r <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q <= bus.dividend[2*WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r <= bus.dividend[2*WIDTH-1];
`endif
                        // Early exits report the raw low dividend byte as remainder.
                        if (div_zero) begin
                            dbz_r       <= 1'b1;
                            quotient_r  <= QUOTIENT_SAT;
                            remainder_r <= bus.dividend[WIDTH-1:0];
                        end else if (too_big) begin
                            ovf_r       <= 1'b1;
                            quotient_r  <= QUOTIENT_SAT;
                            remainder_r <= bus.dividend[WIDTH-1:0];
                        end
                    end
                end
                ITER: begin
                    p     <= as_y;
                    q     <= {q[WIDTH-2:0], ~as_y[WIDTH]};
                    count <= count - 1'b1;
                end
                FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    quotient_r  <= neg_q ? -q : q;
                    remainder_r <= neg_r ? -rem_mag : rem_mag;
`else
                    quotient_r  <= q;
                    remainder_r <= rem_mag;
`endif
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.result    = {remainder_r, quotient_r};
    assign bus.dbz       = dbz_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (vector table, corner sequences, random vs model)
module tb_seq_divider;

    localparam int W = 8;

    logic clk;
    logic rst;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dbz;
        logic           ovf;
        int             lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer division by the arithmetic definition.
    function automatic vec_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        logic [W-1:0] a_lo;
        a_lo  = a[W-1:0];
        v.a   = a;
        v.b   = b;
        v.dbz = 1'b0;
        v.ovf = 1'b0;
        v.lat = 10;
        if (b == 0) begin
            v.dbz = 1'b1; v.q = 8'hFF; v.r = a_lo; v.lat = 1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            int sa, sb, ma, mb, qi, ri;
            sa = int'($signed(a));
            sb = int'($signed(b));
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            qi = ma / mb;
            ri = ma % mb;
            if (qi >= 128) begin
                v.ovf = 1'b1; v.q = 8'hFF; v.r = a_lo; v.lat = 1;
            end else begin
                v.q = 8'(((sa < 0) != (sb < 0)) ? -qi : qi);
                v.r = 8'((sa < 0) ? -ri : ri);
            end
`else
            int ua, ub;
            ua = int'(a);
            ub = int'(b);
            if (ua / ub > 255) begin
                v.ovf = 1'b1; v.q = 8'hFF; v.r = a_lo; v.lat = 1;
            end else begin
                v.q = 8'(ua / ub);
                v.r = 8'(ua % ub);
            end
`endif
        end
        return v;
    endfunction

    // Issue one request; lat counts edges from the accepting edge until done is seen.
    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cyc);
        @(negedge clk);
        bus.go       = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.go       = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        lat      = 1;
        busy_cyc = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busy_cyc++;
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        int lat, bc;
        run_op(v.a, v.b, lat, bc);
        chk({tag, " latency"},   lat,           v.lat);
        chk({tag, " busy_cyc"},  bc,            v.lat);
        chk({tag, " quotient"},  bus.quotient,  v.q);
        chk({tag, " remainder"}, bus.remainder, v.r);
        chk({tag, " result"},    bus.result,    {v.r, v.q});
        chk({tag, " dbz"},       bus.dbz,       v.dbz);
        chk({tag, " ovf"},       bus.ovf,       v.ovf);
        @(posedge clk);
        #1;
        chk({tag, " done_single"}, bus.done, 1'b0);
        chk({tag, " busy_after"},  bus.busy, 1'b0);
    endtask

    initial begin
        int pulses;
        logic [W-1:0] cap_q, cap_r;

`ifdef SEQ_DIVIDER_SIGNED_EN
        tbl.push_back('{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 10});  // -100 / 7
        tbl.push_back('{16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 10});  // 100 / -7
        tbl.push_back('{16'hC000, 8'h7F, 8'hFF, 8'h00, 1'b0, 1'b1, 1});   // -16384 / 127
        tbl.push_back('{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1});   // dbz
        tbl.push_back('{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 10});  // -100 / -7
        tbl.push_back('{16'hC080, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 1});   // true -128 flagged
        tbl.push_back('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 10});  // 100 / 7
`else
        tbl.push_back('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 10});
        tbl.push_back('{16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 10});
        tbl.push_back('{16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1'b0, 1});
        tbl.push_back('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 10});
        tbl.push_back('{16'h0800, 8'h08, 8'hFF, 8'h00, 1'b0, 1'b1, 1});
        tbl.push_back('{16'h07FF, 8'h08, 8'hFF, 8'h07, 1'b0, 1'b0, 10});
        tbl.push_back('{16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1});
        tbl.push_back('{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 10});
        tbl.push_back('{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 10});
        tbl.push_back('{16'h0005, 8'h01, 8'h05, 8'h00, 1'b0, 1'b0, 10});
`endif

        // Reset state
        rst = 1'b0; bus.go = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset quotient", bus.quotient, 8'h00);
        chk("reset remainder", bus.remainder, 8'h00);
        chk("reset dbz", bus.dbz, 1'b0);
        chk("reset ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // go held high through a whole operation, operands changing every cycle
        @(negedge clk);
        bus.go = 1'b1; bus.dividend = 16'h0064; bus.divisor = 8'h07;
        pulses = 0; cap_q = '0; cap_r = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                cap_q = bus.quotient;
                cap_r = bus.remainder;
                bus.go = 1'b0;
            end
            bus.dividend = 16'($urandom);
            bus.divisor  = 8'($urandom);
        end
        bus.go = 1'b0;
        chk("go_held pulses", pulses, 1);
        chk("go_held quotient", cap_q, 8'h0E);
        chk("go_held remainder", cap_r, 8'h02);

        // Reset on the 4th ITER edge abandons the operation
        @(negedge clk);
        bus.go = 1'b1; bus.dividend = 16'h1234; bus.divisor = 8'h56;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst done", bus.done, 1'b0);
        chk("midrst quotient", bus.quotient, 8'h00);
        chk("midrst remainder", bus.remainder, 8'h00);
        chk("midrst dbz", bus.dbz, 1'b0);
        chk("midrst ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        apply(model(16'h0064, 8'h07), "after_rst");

        // Randomized against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [2*W-1:0] a;
            logic [W-1:0]   b;
            b = 8'($urandom);
            if ($urandom_range(0, 9) == 0) b = '0;
            a = 16'($urandom);
            if (b != 0 && $urandom_range(0, 1) == 1)
                a = {8'($urandom_range(0, int'(b) - 1)), 8'($urandom)};
            apply(model(a, b), $sformatf("rnd%0d a=%0h b=%0h", i, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential non-restoring divider: 16-bit dividend ÷ 8-bit divisor → 8-bit quotient + 8-bit remainder.
- Inverse companion of the radix-4 Booth multiplier datapath; result packing mirrors the multiplier's {acc, Mpand} output.
- Internal FSM controller with a Go/done handshake; one quotient bit per clock.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH; iteration counter is clog2(WIDTH) bits.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, reset; synchronous, active-low.
- go, input, 1, start request; sampled only in IDLE.
- dividend, input, 2*WIDTH, captured on the accepting edge.
- divisor, input, WIDTH, captured on the accepting edge.
- busy, output, 1, high from the accepting edge until the DONE cycle ends.
- done, output, 1, single-cycle completion pulse.
- quotient, output, WIDTH, held until the next accepted go.
- remainder, output, WIDTH, held until the next accepted go.
- result, output, 2*WIDTH, {remainder, quotient}.
- dbz, output, 1, divide-by-zero flag; valid with done, held.
- ovf, output, 1, quotient-overflow flag; valid with done, held.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; busy, done, dbz, ovf, quotient, remainder all 0. Applies mid-operation; the operation in progress is abandoned.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - On go=1, capture operands; P (WIDTH+1 bits, signed) = {0, dividend[15:8]}; Q = dividend[7:0]; D = divisor; count = WIDTH-1.
  - If D==0: dbz=1, quotient=8'hFF, remainder=dividend[7:0], next=DONE.
  - Else if dividend[15:8] >= D: ovf=1, quotient=8'hFF, remainder=dividend[7:0], next=DONE.
  - Else next=ITER.
- ITER (one edge per iteration):
  - Shift {P,Q} left by 1.
  - If old P >= 0, P = P - D; else P = P + D.
  - Q[0] = ~P_new[WIDTH].
  - Decrement count; when count==0 at the edge, next=FIX.
- FIX:
  - If P < 0, P = P + D.
  - Load quotient = Q and remainder = P[WIDTH-1:0]; next=DONE.
- DONE: done=1 for exactly this cycle; next=IDLE.
- Latency:
  - Normal: go accepted at edge E0; done high in the cycle after edge E(WIDTH+1). For WIDTH=8, done is visible after 10 edges.
  - dbz/ovf: done high in the cycle after E0 + 1 edge.
- go while busy or in DONE: ignored; no queuing. busy=0 in IDLE only.
- dbz/ovf are cleared when the next go is accepted.
- Arithmetic: add/sub on WIDTH+1 bits, two's complement, carry out discarded.
- Operand inputs may change freely after the accepting edge.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - The accepting edge stores magnitudes |dividend| (16-bit unsigned; 0x8000 → 32768) and |divisor|.
  - ovf is set if |dividend|[15:7] >= |divisor|, i.e. quotient magnitude ≥128. A true result of -128 is deliberately flagged ovf.
  - FIX negates the quotient if the operand signs differ.
  - FIX negates the remainder if the dividend is negative; the remainder takes the dividend's sign.
  - dbz behaviour is unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Package div_pkg: state enum (IDLE, ITER, FIX, DONE), WIDTH default, DBZ_QUOTIENT constant (all ones), counter width function.
- One sub-module, div_addsub: (WIDTH+1)-bit add/subtract selected by a sub control, ripple form matching the existing adder style.
- FSM and registers stay in seq_divider.

Test Plan:
- 100 / 7 → quotient=14 (0x0E), remainder=2; done pulses exactly once, 10 edges after accept; busy high for 10 cycles.
- 0x00FF / 0x10 → quotient=0x0F, remainder=0x0F; result=0x0F0F.
- 0x1234 / 0 → dbz=1, quotient=0xFF, remainder=0x34, done 1 edge after accept; then 0x0064 / 7 clears dbz.
- 0x0800 / 0x08 → ovf=1, quotient=0xFF, remainder=0x00. 0x07FF / 0x08 → quotient=0xFF, remainder=0x07, ovf=0.
- go held high through a whole operation with changing operands → only the first operands are used, one done pulse; rst=0 on the 4th ITER edge → IDLE, all outputs 0 next cycle, new go is accepted normally.
- SEQ_DIVIDER_SIGNED_EN: -100 / 7 → quotient=0xF2 (-14), remainder=0xFE (-2); 100 / -7 → quotient=0xF2, remainder=0x02; -16384 / 127 → ovf=1.
